// File: rtl/mdio_pkg.sv
// mdio_pkg
// Constants and types shared by the MDIO management-side generator and by
// receptorMDIO: frame layout, opcodes, widths, FSM state encoding and the
// debug view of the generator FSM.
package mdio_pkg;

  localparam int FRAME_W = 32;
  localparam int DATA_W  = 16;

  // Frame field bit positions (MSB first on the wire).
  localparam int FRM_ST_MSB    = 31;
  localparam int FRM_ST_LSB    = 30;
  localparam int FRM_OP_MSB    = 29;
  localparam int FRM_OP_LSB    = 28;
  localparam int FRM_PHYAD_MSB = 27;
  localparam int FRM_PHYAD_LSB = 23;
  localparam int FRM_REGAD_MSB = 22;
  localparam int FRM_REGAD_LSB = 18;
  localparam int FRM_TA_MSB    = 17;
  localparam int FRM_TA_LSB    = 16;
  localparam int FRM_DATA_MSB  = 15;
  localparam int FRM_DATA_LSB  = 0;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  // Bit counter: loaded with the index of the first frame bit; a read frame
  // leaves SEND after the bit whose index is READ_LAST_TX (end of TA).
  localparam logic [4:0] BIT_CNT_INIT = 5'd31;
  localparam logic [4:0] READ_LAST_TX = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RECV = 2'd2
  } mdio_state_e;

  // Debug view of the generator: FSM state, bit counter and MDC strobes.
  typedef struct packed {
    mdio_state_e state;
    logic [4:0]  bit_cnt;
    logic        rise_tick;
    logic        fall_tick;
  } mdio_dbg_t;

  // Only OP=10 is a read; every other opcode is serialized as a write.
  function automatic logic is_read_op(input logic [1:0] op);
    return op == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_generator_mdc_divider.sv
// mdc_divider
// Generates MDC from CLK. While en_i is low MDC is held at 0 and the phase
// counter is cleared, so the first rising MDC edge comes MDC_HALF CLK cycles
// after en_i goes high.
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   en_i         run the divider (high while a frame is in progress)
//   mdc_o        registered management clock
//   rise_tick_o  high in the cycle whose closing CLK edge takes MDC to 1
//   fall_tick_o  high in the cycle whose closing CLK edge takes MDC to 0
module mdc_divider #(
  parameter int MDC_HALF = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic mdc_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);

  localparam int CW = (MDC_HALF > 1) ? $clog2(MDC_HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MDC_HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdc_q, mdc_d;
  logic          half_done;

  assign half_done   = en_i && (cnt_q == CNT_LAST);
  assign rise_tick_o = half_done && !mdc_q;
  assign fall_tick_o = half_done &&  mdc_q;
  assign mdc_o       = mdc_q;

  always_comb begin
    cnt_d = cnt_q;
    mdc_d = mdc_q;
    if (!en_i) begin
      cnt_d = '0;
      mdc_d = 1'b0;
    end else if (half_done) begin
      cnt_d = '0;
      mdc_d = !mdc_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      mdc_q <= mdc_d;
    end
  end

endmodule

// File: rtl/mdio_generator.sv
// mdio_generator
// Management-side MDIO controller. A 0->1 edge on MDIO_START seen in IDLE
// latches T_DATA and serializes it MSB first on MDIO_OUT (MDIO_OE=1), with
// MDIO_OUT changing only as MDC falls. Read frames (OP=10) release the line
// after TA and shift 16 bits of MDIO_IN into RD_DATA, then pulse DATA_RDY.
// Ports:
//   CLK         system clock
//   reset       asynchronous active-low reset
//   MDIO_START  start request (rising edge, ignored while busy)
//   T_DATA      32-bit management frame
//   MDIO_IN     serial data from the PHY
//   MDC         management clock, 0 when idle
//   MDIO_OUT    serial frame bit
//   MDIO_OE     high while this block drives the line
//   RD_DATA     last captured read data
//   DATA_RDY    one-CLK pulse when RD_DATA is updated
//   STATE_DBG   FSM state, bit counter and MDC strobes
// Handshake: no valid/ready; a start is accepted only in IDLE, and requests
// arriving while busy are dropped rather than queued.
module mdio_generator
  import mdio_pkg::*;
#(
  parameter int MDC_HALF = 1
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               MDIO_START,
  input  logic [FRAME_W-1:0] T_DATA,
  input  logic               MDIO_IN,
  output logic               MDC,
  output logic               MDIO_OUT,
  output logic               MDIO_OE,
  output logic [DATA_W-1:0]  RD_DATA,
  output logic               DATA_RDY,
  output mdio_dbg_t          STATE_DBG
);

  mdio_state_e        state_q, state_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic               rd_op_q, rd_op_d;
  logic [DATA_W-2:0]  rx_q, rx_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rdy_q, rdy_d;
  logic               start_q;
  logic               start_edge;
  logic               rise_tick, fall_tick;

  mdc_divider #(.MDC_HALF(MDC_HALF)) u_mdc_divider (
    .clk_i       (CLK),
    .rst_ni      (reset),
    .en_i        (state_q != IDLE),
    .mdc_o       (MDC),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  assign start_edge = MDIO_START && !start_q;

  // The shift register MSB is the bit on the wire; it only moves on
  // fall_tick, so MDIO_OUT is stable across every MDC rising edge.
  assign MDIO_OE   = (state_q == SEND);
  assign MDIO_OUT  = (state_q == SEND) && shift_q[FRAME_W-1];
  assign RD_DATA   = rd_data_q;
  assign DATA_RDY  = rdy_q;
  assign STATE_DBG = '{state: state_q, bit_cnt: bit_cnt_q,
                       rise_tick: rise_tick, fall_tick: fall_tick};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rd_op_d   = rd_op_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          shift_d   = T_DATA;
          bit_cnt_d = BIT_CNT_INIT;
          rd_op_d   = is_read_op(T_DATA[FRM_OP_MSB:FRM_OP_LSB]);
          state_d   = SEND;
        end
      end
      SEND: begin
        if (fall_tick) begin
          shift_d = {shift_q[FRAME_W-2:0], 1'b0};
          if (rd_op_q && (bit_cnt_q == READ_LAST_TX)) begin
            bit_cnt_d = bit_cnt_q - 5'd1;
            state_d   = RECV;
          end else if (bit_cnt_q == 5'd0) begin
            state_d = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end
      RECV: begin
        // fall_tick marks the CLK edge that ends the MDC high phase.
        if (fall_tick) begin
          rx_d = {rx_q[DATA_W-3:0], MDIO_IN};
          if (bit_cnt_q == 5'd0) begin
            rd_data_d = {rx_q, MDIO_IN};
            rdy_d     = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rd_op_q   <= 1'b0;
      rx_q      <= '0;
      rd_data_q <= '0;
      rdy_q     <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rd_op_q   <= rd_op_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      rdy_q     <= rdy_d;
      start_q   <= MDIO_START;
    end
  end

endmodule

// File: tb/tb_mdio_generator.sv
module tb_mdio_generator;
  import mdio_pkg::*;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        reset;
  logic        MDIO_START;
  logic [31:0] T_DATA;
  logic        MDIO_IN;
  logic        MDC;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        DATA_RDY;
  mdio_dbg_t   STATE_DBG;

  always #5 CLK = ~CLK;

  mdio_generator #(.MDC_HALF(1)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .MDIO_START (MDIO_START),
    .T_DATA     (T_DATA),
    .MDIO_IN    (MDIO_IN),
    .MDC        (MDC),
    .MDIO_OUT   (MDIO_OUT),
    .MDIO_OE    (MDIO_OE),
    .RD_DATA    (RD_DATA),
    .DATA_RDY   (DATA_RDY),
    .STATE_DBG  (STATE_DBG)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  // results of the last observe() window
  logic [31:0] tx_bits;
  int          tx_n, oe_cnt, rdy_cnt, oe_fall_k, rdy_k, frames, mdc_rises, rd_changes;
  logic [15:0] rd_at_rdy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge: the following posedge is edge 0. Returns at the
  // negedge after edge 0.
  task automatic start(input logic [31:0] frame);
    T_DATA     = frame;
    MDIO_START = 1'b1;
    exp_q.push_back(frame);
    @(negedge CLK);
  endtask

  // Observes n cycles, k = 0..n-1 being the negedge after edge k.
  // MDIO_START drops at k==hold; poke_k>=0 makes a second start edge plus a
  // T_DATA change that the busy block must ignore. The PHY model drives
  // reply bit for frame bit j at the MDC fall that opens bit j (edge 2j).
  task automatic observe(input int n, input int hold, input logic [15:0] reply, input int poke_k);
    logic        prev_mdc, prev_oe;
    logic [15:0] rd0;
    prev_mdc = 1'b0; prev_oe = 1'b0; rd0 = RD_DATA;
    tx_bits = '0; tx_n = 0; oe_cnt = 0; rdy_cnt = 0; oe_fall_k = -1;
    rdy_k = -1; frames = 0; mdc_rises = 0; rd_changes = 0; rd_at_rdy = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(negedge CLK);
      if (MDIO_OE && !prev_oe) frames++;
      if (MDIO_OE) oe_cnt++;
      if (prev_oe && !MDIO_OE && oe_fall_k < 0) oe_fall_k = k;
      if (MDC && !prev_mdc) begin
        mdc_rises++;
        if (MDIO_OE) begin
          tx_bits = {tx_bits[30:0], MDIO_OUT};
          tx_n++;
        end
      end
      if (DATA_RDY) begin
        rdy_cnt++;
        rdy_k = k;
        rd_at_rdy = RD_DATA;
      end
      if (!DATA_RDY && RD_DATA !== rd0) rd_changes++;
      prev_mdc = MDC;
      prev_oe  = MDIO_OE;
      if (k == hold) MDIO_START = 1'b0;
      if (k == poke_k) begin
        MDIO_START = 1'b1;
        T_DATA     = ~T_DATA;
      end
      if (poke_k >= 0 && k == poke_k + 2) MDIO_START = 1'b0;
      if (k % 2 == 0 && k >= 32 && k <= 62) MDIO_IN = reply[31 - k / 2];
    end
  endtask

  // Compares serialized bits against the next expected frame; a read frame
  // only drives its upper 16 bits.
  task automatic check_tx(input string tag, input int nbits);
    logic [31:0] exp;
    check({tag, "_exp_q"}, exp_q.size(), 1);
    check({tag, "_tx_n"}, tx_n, nbits);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      if (nbits == 32) check({tag, "_tx_bits"}, tx_bits, exp);
      else check({tag, "_tx_bits"}, {16'h0, tx_bits[15:0]}, {16'h0, exp[31:16]});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; MDIO_START = 1'b0; T_DATA = '0; MDIO_IN = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_mdc", MDC, 0);
    check("rst_oe", MDIO_OE, 0);
    check("rst_out", MDIO_OUT, 0);
    check("rst_rd_data", RD_DATA, 0);
    check("rst_rdy", DATA_RDY, 0);
    check("rst_state", 32'(STATE_DBG.state), 32'(IDLE));
    reset = 1'b1;
    repeat (2) @(negedge CLK);

    // 1: write frame
    start(32'h5123_5555);
    observe(70, 1, 16'h0000, -1);
    check_tx("t1", 32);
    check("t1_oe_cycles", oe_cnt, 64);
    check("t1_oe_fall_edge", oe_fall_k, 64);
    check("t1_rdy_cnt", rdy_cnt, 0);
    check("t1_frames", frames, 1);
    check("t1_mdc_rises", mdc_rises, 32);
    check("t1_mdc_idle", MDC, 0);

    // 2: read frame, PHY replies AAAA
    start(32'h6114_0000);
    observe(70, 1, 16'hAAAA, -1);
    check_tx("t2", 16);
    check("t2_oe_fall_edge", oe_fall_k, 32);
    check("t2_oe_cycles", oe_cnt, 32);
    check("t2_rdy_cnt", rdy_cnt, 1);
    check("t2_rdy_edge", rdy_k, 64);
    check("t2_rd_at_rdy", rd_at_rdy, 16'hAAAA);
    check("t2_rd_hold", RD_DATA, 16'hAAAA);
    check("t2_mdc_rises", mdc_rises, 32);

    // 3: MDIO_START held high for 100 CLK
    start(32'h5A3C_F00F);
    observe(110, 100, 16'h0000, -1);
    check_tx("t3", 32);
    check("t3_frames", frames, 1);
    check("t3_oe_cycles", oe_cnt, 64);

    // 4: second start edge and T_DATA change at bit 10 of a write
    start(32'h5F0C_A53C);
    observe(100, 1, 16'h0000, 20);
    check_tx("t4", 32);
    check("t4_frames", frames, 1);
    check("t4_oe_cycles", oe_cnt, 64);
    check("t4_rdy_cnt", rdy_cnt, 0);

    // OP=11 is serialized as a write
    start(32'h7ABC_DEF0);
    observe(70, 1, 16'hFFFF, -1);
    check_tx("op11", 32);
    check("op11_oe_cycles", oe_cnt, 64);
    check("op11_rdy_cnt", rdy_cnt, 0);

    // 5: reset in the middle of bit 10 of a read
    start(32'h6114_0000);
    observe(22, 1, 16'h0000, -1);
    void'(exp_q.pop_front());
    check("t5_mdc_before", MDC, 1);
    check("t5_oe_before", MDIO_OE, 1);
    reset = 1'b0;
    #1;
    check("t5_mdc_rst", MDC, 0);
    check("t5_oe_rst", MDIO_OE, 0);
    check("t5_out_rst", MDIO_OUT, 0);
    check("t5_rd_data_rst", RD_DATA, 0);
    check("t5_state_rst", 32'(STATE_DBG.state), 32'(IDLE));
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    start(32'h6AC6_0000);
    observe(70, 1, 16'h1234, -1);
    check_tx("t5b", 16);
    check("t5b_rdy_edge", rdy_k, 64);
    check("t5b_rd_at_rdy", rd_at_rdy, 16'h1234);
    check("t5b_rdy_cnt", rdy_cnt, 1);

    // 6: read, then a write started at edge 65
    start(32'h6114_0000);
    observe(65, 1, 16'h0F0F, -1);
    check_tx("t6r", 16);
    check("t6r_rdy_edge", rdy_k, 64);
    check("t6r_rd_at_rdy", rd_at_rdy, 16'h0F0F);
    start(32'h5123_AAAA);
    observe(70, 1, 16'h0000, -1);
    check_tx("t6w", 32);
    check("t6w_frames", frames, 1);
    check("t6w_oe_fall_edge", oe_fall_k, 64);
    check("t6w_rdy_cnt", rdy_cnt, 0);
    check("t6w_rd_changes", rd_changes, 0);
    check("t6w_rd_hold", RD_DATA, 16'h0F0F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
